// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory-side bus of the
// shared-memory arbiter. The slave modport is the arbiter; master is its environment.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported instruction/data memory between fetch and load/store,
// one fixed-latency access at a time, with a starvation guard for fetch.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic {S_IDLE, S_WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  localparam logic [3:0] LAT_MAX    = 4'(MEM_LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  store_q, store_d;
  logic [3:0]            lat_q, lat_d;
  logic [3:0]            starve_q, starve_d;
  logic                  fetch_wins;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;

  // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    store_d  = store_q;
    lat_d    = lat_q;
    starve_d = starve_q;

    fetch_wins = bus.if_req && (!bus.d_req || starve_q == STARVE_MAX);
    addr_sel   = fetch_wins ? bus.if_addr : bus.d_addr;
    rdata_sel  = store_q ? '0 : bus.mem_rdata;

    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rdata   = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Issue strobes are combinational, so they are held off while reset is asserted.
        if (reset && (bus.if_req || bus.d_req)) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = addr_sel;
          state_d      = S_WAIT;
          lat_d        = 4'd1;
          if (fetch_wins) begin
            bus.if_gnt = 1'b1;
            owner_d    = OWN_IF;
            store_d    = 1'b0;
            starve_d   = '0;
          end else begin
            bus.d_gnt     = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_wdata = bus.d_wdata;
            owner_d       = OWN_D;
            store_d       = bus.d_we;
            if (bus.if_req && starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
          end
        end
      end
      S_WAIT: begin
        bus.busy = 1'b1;
        if (lat_q == LAT_MAX) begin
          state_d = S_IDLE;
          lat_d   = '0;
          if (owner_q == OWN_IF) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = rdata_sel;
          end else begin
            bus.d_rvalid = 1'b1;
            bus.d_rdata  = rdata_sel;
          end
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_IF;
      store_q  <= 1'b0;
      lat_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      store_q  <= store_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// every cycle compared against a countdown-based transaction model.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int SL  = 4;

  logic clk;
  logic reset;
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: cycles left until the response, who owns it, fetch lost count.
  int m_left   = 0;
  int m_starve = 0;
  bit m_fetch  = 1'b0;
  bit m_store  = 1'b0;

  bit    keep_if   = 1'b0;
  bit    keep_d    = 1'b0;
  bit    rand_mode = 1'b0;
  string gseq      = "";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_and_check(output bit g_if, output bit g_d);
    logic          e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_en, e_we, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_if_rdata, e_d_rdata;
    bit            fw;
    e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_en = 0; e_we = 0; e_busy = 0;
    e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
    if (!reset) begin
      m_left   = 0;
      m_starve = 0;
    end else if (m_left == 0) begin
      if (bus.if_req || bus.d_req) begin
        fw   = bus.if_req && (!bus.d_req || m_starve == SL);
        e_en = 1;
        if (fw) begin
          e_if_gnt = 1;
          e_addr   = bus.if_addr;
          m_starve = 0;
        end else begin
          e_d_gnt = 1;
          e_we    = bus.d_we;
          e_addr  = bus.d_addr;
          e_wdata = bus.d_wdata;
          if (bus.if_req && m_starve < SL) m_starve++;
        end
        m_left  = LAT;
        m_fetch = fw;
        m_store = !fw && bus.d_we;
      end
    end else begin
      e_busy = 1;
      m_left--;
      if (m_left == 0) begin
        if (m_fetch) begin
          e_if_rv    = 1;
          e_if_rdata = bus.mem_rdata;
        end else begin
          e_d_rv    = 1;
          e_d_rdata = m_store ? '0 : bus.mem_rdata;
        end
      end
    end
    check("if_gnt",    64'(bus.if_gnt),    64'(e_if_gnt));
    check("d_gnt",     64'(bus.d_gnt),     64'(e_d_gnt));
    check("mem_en",    64'(bus.mem_en),    64'(e_en));
    check("mem_we",    64'(bus.mem_we),    64'(e_we));
    check("mem_addr",  64'(bus.mem_addr),  64'(e_addr));
    check("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
    check("if_rvalid", 64'(bus.if_rvalid), 64'(e_if_rv));
    check("if_rdata",  64'(bus.if_rdata),  64'(e_if_rdata));
    check("d_rvalid",  64'(bus.d_rvalid),  64'(e_d_rv));
    check("d_rdata",   64'(bus.d_rdata),   64'(e_d_rdata));
    check("busy",      64'(bus.busy),      64'(e_busy));
    g_if = e_if_gnt;
    g_d  = e_d_gnt;
  endtask

  task automatic random_drive();
    if (!bus.if_req) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
      end
    end else if ($urandom_range(0, 15) == 0) begin
      bus.if_req = 1'b0;
    end
    if (!bus.d_req) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
    end else if ($urandom_range(0, 15) == 0) begin
      bus.d_req = 1'b0;
    end
  endtask

  task automatic cycle();
    bit g_if, g_d;
    @(negedge clk);
    if (bus.if_gnt) gseq = {gseq, "I"};
    if (bus.d_gnt)  gseq = {gseq, "D"};
    model_and_check(g_if, g_d);
    @(posedge clk);
    #1;
    bus.mem_rdata = $urandom;
    if (g_if) begin
      if (keep_if) bus.if_addr = bus.if_addr + 32'd4;
      else         bus.if_req  = 1'b0;
    end
    if (g_d) begin
      if (keep_d) bus.d_addr = bus.d_addr + 32'd4;
      else        bus.d_req  = 1'b0;
    end
    if (rand_mode) random_drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    run(2);
    reset = 1'b1;
    run(1);

    // Single fetch, memory returns a known instruction in cycle 2
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    run(2);
    bus.mem_rdata = 32'h0050_0093;
    run(3);

    // Simultaneous fetch and load: data first, fetch right after
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h80;
    bus.d_wdata = 32'h1234_5678;
    run(8);

    // Store: acknowledged with zero read data
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h84;
    bus.d_wdata = 32'hDEAD_BEEF;
    run(5);

    // Starvation: both requests held continuously
    gseq        = "";
    keep_if     = 1'b1;
    keep_d      = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h200;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h400;
    run(20);
    total++;
    assert (gseq == "DDDDIDD") passed++;
    else $error("FAIL starve_seq: observed %s expected DDDDIDD", gseq);
    keep_if    = 1'b0;
    keep_d     = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    run(4);

    // Reset in the cycle after a load grant; no response may follow
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h90;
    run(1);
    reset = 1'b0;
    run(2);
    reset = 1'b1;
    run(5);

    // Back-to-back fetches with advancing address
    keep_if     = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    gseq        = "";
    run(9);
    total++;
    assert (gseq == "III") passed++;
    else $error("FAIL b2b_fetch: observed %s expected III", gseq);
    keep_if    = 1'b0;
    bus.if_req = 1'b0;
    run(4);

    // Random traffic against the model
    rand_mode = 1'b1;
    run(400);
    rand_mode  = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    run(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
